// File: rtl/hack_rom_loader_pkg.sv
// Shared definitions for the Hack instruction ROM loader: loader state encoding
// and the fixed Hack instruction width.
package hack_rom_loader_pkg;

    localparam int HACK_WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_WORD_HI,
        ST_WORD_LO,
        ST_RUN,
        ST_ERROR
    } loaderState_t;

endpackage

// File: rtl/hack_rom_mem.sv
// Instruction store: one synchronous write port for the loader, one
// combinational read port for CPU fetch. Contents survive reset.
module hack_rom_mem
    import hack_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = HACK_WORD_W
) (
    input  logic              clock,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WORD_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WORD_W-1:0] rdData
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Loads a length-prefixed program image from a byte stream into the Hack ROM,
// holding the CPU in reset until the image is complete.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for load_start, CPU held in reset
// ST_LEN_HI  | expecting length high byte
// ST_LEN_LO  | expecting length low byte
// ST_WORD_HI | expecting high byte of next word
// ST_WORD_LO | expecting low byte, writes the word
// ST_RUN     | image complete, CPU released, ROM visible
// ST_ERROR   | header length too large, waits for load_start
module hack_rom_loader
    import hack_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = HACK_WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [15:0]       pc,
    output logic [WORD_W-1:0] instruction,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0] CAPACITY = 17'(2**ADDR_W);

    loaderState_t state;
    loaderState_t stateNext;

    logic [15:0]       lenReg;
    logic [7:0]        hiByte;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W:0]   wordCount;
    logic              accept;
    logic              wrEn;
    logic              lastWord;
    logic [15:0]       lenNew;
    logic [WORD_W-1:0] romData;
    logic              unusedPcHi;

    assign accept   = rx_valid && rx_ready;
    assign lenNew   = {lenReg[15:8], rx_data};
    assign lastWord = (17'(wordCount) + 17'd1) == {1'b0, lenReg};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // load_start overrides any byte accepted in the same cycle
    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        if (load_start) begin
            stateNext = ST_LEN_HI;
        end else begin
            case (state)
                ST_LEN_HI:  if (accept) stateNext = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (accept) begin
                        if (lenNew == 16'd0) begin
                            stateNext = ST_RUN;
                        end else if ({1'b0, lenNew} > CAPACITY) begin
                            stateNext = ST_ERROR;
                        end else begin
                            stateNext = ST_WORD_HI;
                        end
                    end
                end
                ST_WORD_HI: if (accept) stateNext = ST_WORD_LO;
                ST_WORD_LO: begin
                    if (accept) begin
                        wrEn      = 1'b1;
                        stateNext = lastWord ? ST_RUN : ST_WORD_HI;
                    end
                end
                default: stateNext = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lenReg    <= '0;
            hiByte    <= '0;
            wrAddr    <= '0;
            wordCount <= '0;
        end else if (load_start) begin
            wrAddr    <= '0;
            wordCount <= '0;
        end else begin
            if (state == ST_LEN_HI && accept) lenReg[15:8] <= rx_data;
            if (state == ST_LEN_LO && accept) lenReg[7:0]  <= rx_data;
            if (state == ST_WORD_HI && accept) hiByte      <= rx_data;
            if (wrEn) begin
                wrAddr    <= wrAddr + 1'b1;
                wordCount <= wordCount + 1'b1;
            end
        end
    end

    hack_rom_mem #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) u_mem (
        .clock (clock),
        .wrEn  (wrEn),
        .wrAddr(wrAddr),
        .wrData({hiByte, rx_data}),
        .rdAddr(pc[ADDR_W-1:0]),
        .rdData(romData)
    );

    // upper pc bits are ignored so fetch wraps within the ROM
    assign unusedPcHi = ^pc[15:ADDR_W];

    assign rx_ready    = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                         (state == ST_WORD_HI) || (state == ST_WORD_LO);
    assign cpu_reset   = (state != ST_RUN);
    assign load_done   = (state == ST_RUN);
    assign load_error  = (state == ST_ERROR);
    assign word_count  = wordCount;
    assign instruction = (state == ST_RUN) ? romData : '0;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: status outputs checked directly,
// ROM contents checked through a scoreboard of expected (pc, word) pairs.
module tb_hack_rom_loader;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } expWord_t;

    logic        clock;
    logic        reset;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;
    expWord_t sbQ[$];
    logic [7:0] bs[$];

    hack_rom_loader #(.ADDR_W(15), .WORD_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .pc         (pc),
        .instruction(instruction),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) begin
            checkVal("rx_ready_timeout", 32'(rx_ready), 32'd1);
        end else begin
            rx_data  = b;
            rx_valid = 1'b1;
            @(negedge clock);
            rx_valid = 1'b0;
        end
    endtask

    task automatic sendStream(input logic [7:0] q[$], input int gapN);
        foreach (q[i]) begin
            sendByte(q[i]);
            if (i != q.size() - 1) repeat (gapN) @(negedge clock);
        end
    endtask

    task automatic expectWord(input logic [15:0] a, input logic [15:0] w);
        expWord_t e;
        e.pc   = a;
        e.word = w;
        sbQ.push_back(e);
    endtask

    task automatic drainSb(input string tag);
        expWord_t e;
        while (sbQ.size() > 0) begin
            e  = sbQ.pop_front();
            pc = e.pc;
            #1;
            checkVal(tag, 32'(instruction), 32'(e.word));
        end
        pc = 16'h0000;
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        pc         = 16'h0000;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 1: idle after reset
        checkVal("t1_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("t1_rx_ready", 32'(rx_ready), 32'd0);
        checkVal("t1_load_done", 32'(load_done), 32'd0);
        checkVal("t1_load_error", 32'(load_error), 32'd0);
        checkVal("t1_word_count", 32'(word_count), 32'd0);
        checkVal("t1_instruction", 32'(instruction), 32'h0000);

        // 2: two-word image
        pulseStart();
        checkVal("t2_rx_ready_loading", 32'(rx_ready), 32'd1);
        checkVal("t2_cpu_reset_loading", 32'(cpu_reset), 32'd1);
        expectWord(16'd0, 16'hEAB8);
        expectWord(16'd1, 16'hEFF8);
        bs = '{8'h00, 8'h02, 8'hEA, 8'hB8, 8'hEF, 8'hF8};
        sendStream(bs, 0);
        checkVal("t2_load_done", 32'(load_done), 32'd1);
        checkVal("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        checkVal("t2_word_count", 32'(word_count), 32'd2);
        checkVal("t2_rx_ready", 32'(rx_ready), 32'd0);
        drainSb("t2_rom");

        // 3: zero-length image, ROM untouched
        pulseStart();
        checkVal("t3_cpu_reset_restart", 32'(cpu_reset), 32'd1);
        checkVal("t3_load_done_cleared", 32'(load_done), 32'd0);
        checkVal("t3_instr_hidden", 32'(instruction), 32'h0000);
        checkVal("t3_word_count_cleared", 32'(word_count), 32'd0);
        bs = '{8'h00, 8'h00};
        sendStream(bs, 0);
        checkVal("t3_load_done", 32'(load_done), 32'd1);
        checkVal("t3_word_count", 32'(word_count), 32'd0);
        expectWord(16'd0, 16'hEAB8);
        drainSb("t3_rom");

        // 4: oversize header, exact-capacity header, then recovery
        pulseStart();
        bs = '{8'h80, 8'h01};
        sendStream(bs, 0);
        checkVal("t4_load_error", 32'(load_error), 32'd1);
        checkVal("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("t4_rx_ready", 32'(rx_ready), 32'd0);
        checkVal("t4_load_done", 32'(load_done), 32'd0);
        repeat (3) @(negedge clock);
        checkVal("t4_error_sticky", 32'(load_error), 32'd1);
        pulseStart();
        checkVal("t4_error_cleared", 32'(load_error), 32'd0);
        bs = '{8'h80, 8'h00};
        sendStream(bs, 0);
        checkVal("t4_cap_no_error", 32'(load_error), 32'd0);
        checkVal("t4_cap_rx_ready", 32'(rx_ready), 32'd1);
        pulseStart();
        expectWord(16'd0, 16'h0005);
        bs = '{8'h00, 8'h01, 8'h00, 8'h05};
        sendStream(bs, 0);
        checkVal("t4_load_done", 32'(load_done), 32'd1);
        checkVal("t4_word_count", 32'(word_count), 32'd1);
        drainSb("t4_rom");

        // 5: restart mid-load with a byte offered in the same cycle
        pulseStart();
        bs = '{8'h00, 8'h02, 8'hEA};
        sendStream(bs, 0);
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h55;
        @(negedge clock);
        load_start = 1'b0;
        rx_valid   = 1'b0;
        checkVal("t5_rx_ready", 32'(rx_ready), 32'd1);
        checkVal("t5_word_count", 32'(word_count), 32'd0);
        checkVal("t5_load_done", 32'(load_done), 32'd0);
        bs = '{8'h00, 8'h01, 8'h12, 8'h34};
        sendStream(bs, 0);
        checkVal("t5_load_done_after", 32'(load_done), 32'd1);
        expectWord(16'd0, 16'h1234);
        expectWord(16'h8000, 16'h1234);
        expectWord(16'd1, 16'hEFF8);
        drainSb("t5_rom");

        // 6: rx_valid gaps between bytes
        pulseStart();
        expectWord(16'd0, 16'hEAB8);
        expectWord(16'd1, 16'hEFF8);
        bs = '{8'h00, 8'h02, 8'hEA, 8'hB8, 8'hEF, 8'hF8};
        sendStream(bs, 2);
        checkVal("t6_load_done", 32'(load_done), 32'd1);
        checkVal("t6_word_count", 32'(word_count), 32'd2);
        drainSb("t6_rom");

        // 6b: async reset during WORD_LO, partial image kept
        pulseStart();
        bs = '{8'h00, 8'h03, 8'h11, 8'h22};
        sendStream(bs, 0);
        checkVal("t6_partial_count", 32'(word_count), 32'd1);
        checkVal("t6_partial_done", 32'(load_done), 32'd0);
        sendByte(8'h33);
        #2;
        reset = 1'b0;
        #1;
        checkVal("t6_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkVal("t6_rst_rx_ready", 32'(rx_ready), 32'd0);
        checkVal("t6_rst_load_done", 32'(load_done), 32'd0);
        checkVal("t6_rst_load_error", 32'(load_error), 32'd0);
        checkVal("t6_rst_word_count", 32'(word_count), 32'd0);
        checkVal("t6_rst_instruction", 32'(instruction), 32'h0000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkVal("t6_idle_rx_ready", 32'(rx_ready), 32'd0);
        pulseStart();
        bs = '{8'h00, 8'h00};
        sendStream(bs, 0);
        expectWord(16'd0, 16'h1122);
        expectWord(16'd1, 16'hEFF8);
        drainSb("t6_partial_rom");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
